// File: rtl/sm4_pkg.sv
// Shared SM4 definitions: S-box, FK/CK constants, engine FSM encoding, T transform.
// Latency: n/a (constants and pure combinational functions only).
// Backpressure: n/a.
package sm4_pkg;

    localparam int SM4_BLOCK_W = 128;
    localparam int SM4_WORD_W  = 32;
    localparam int SM4_ROUNDS  = 32;
    localparam int SM4_KEYS_W  = SM4_ROUNDS * SM4_WORD_W;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } sm4_state_t;

    // Element 0 sits in the leftmost byte, so SBOX[x] is the substitution of x.
    localparam logic [0:255][7:0] SBOX = {
        8'hd6, 8'h90, 8'he9, 8'hfe, 8'hcc, 8'he1, 8'h3d, 8'hb7, 8'h16, 8'hb6, 8'h14, 8'hc2, 8'h28, 8'hfb, 8'h2c, 8'h05,
        8'h2b, 8'h67, 8'h9a, 8'h76, 8'h2a, 8'hbe, 8'h04, 8'hc3, 8'haa, 8'h44, 8'h13, 8'h26, 8'h49, 8'h86, 8'h06, 8'h99,
        8'h9c, 8'h42, 8'h50, 8'hf4, 8'h91, 8'hef, 8'h98, 8'h7a, 8'h33, 8'h54, 8'h0b, 8'h43, 8'hed, 8'hcf, 8'hac, 8'h62,
        8'he4, 8'hb3, 8'h1c, 8'ha9, 8'hc9, 8'h08, 8'he8, 8'h95, 8'h80, 8'hdf, 8'h94, 8'hfa, 8'h75, 8'h8f, 8'h3f, 8'ha6,
        8'h47, 8'h07, 8'ha7, 8'hfc, 8'hf3, 8'h73, 8'h17, 8'hba, 8'h83, 8'h59, 8'h3c, 8'h19, 8'he6, 8'h85, 8'h4f, 8'ha8,
        8'h68, 8'h6b, 8'h81, 8'hb2, 8'h71, 8'h64, 8'hda, 8'h8b, 8'hf8, 8'heb, 8'h0f, 8'h4b, 8'h70, 8'h56, 8'h9d, 8'h35,
        8'h1e, 8'h24, 8'h0e, 8'h5e, 8'h63, 8'h58, 8'hd1, 8'ha2, 8'h25, 8'h22, 8'h7c, 8'h3b, 8'h01, 8'h21, 8'h78, 8'h87,
        8'hd4, 8'h00, 8'h46, 8'h57, 8'h9f, 8'hd3, 8'h27, 8'h52, 8'h4c, 8'h36, 8'h02, 8'he7, 8'ha0, 8'hc4, 8'hc8, 8'h9e,
        8'hea, 8'hbf, 8'h8a, 8'hd2, 8'h40, 8'hc7, 8'h38, 8'hb5, 8'ha3, 8'hf7, 8'hf2, 8'hce, 8'hf9, 8'h61, 8'h15, 8'ha1,
        8'he0, 8'hae, 8'h5d, 8'ha4, 8'h9b, 8'h34, 8'h1a, 8'h55, 8'had, 8'h93, 8'h32, 8'h30, 8'hf5, 8'h8c, 8'hb1, 8'he3,
        8'h1d, 8'hf6, 8'he2, 8'h2e, 8'h82, 8'h66, 8'hca, 8'h60, 8'hc0, 8'h29, 8'h23, 8'hab, 8'h0d, 8'h53, 8'h4e, 8'h6f,
        8'hd5, 8'hdb, 8'h37, 8'h45, 8'hde, 8'hfd, 8'h8e, 8'h2f, 8'h03, 8'hff, 8'h6a, 8'h72, 8'h6d, 8'h6c, 8'h5b, 8'h51,
        8'h8d, 8'h1b, 8'haf, 8'h92, 8'hbb, 8'hdd, 8'hbc, 8'h7f, 8'h11, 8'hd9, 8'h5c, 8'h41, 8'h1f, 8'h10, 8'h5a, 8'hd8,
        8'h0a, 8'hc1, 8'h31, 8'h88, 8'ha5, 8'hcd, 8'h7b, 8'hbd, 8'h2d, 8'h74, 8'hd0, 8'h12, 8'hb8, 8'he5, 8'hb4, 8'hb0,
        8'h89, 8'h69, 8'h97, 8'h4a, 8'h0c, 8'h96, 8'h77, 8'h7e, 8'h65, 8'hb9, 8'hf1, 8'h09, 8'hc5, 8'h6e, 8'hc6, 8'h84,
        8'h18, 8'hf0, 8'h7d, 8'hec, 8'h3a, 8'hdc, 8'h4d, 8'h20, 8'h79, 8'hee, 8'h5f, 8'h3e, 8'hd7, 8'hcb, 8'h39, 8'h48
    };

    // Key-schedule constants, kept here so a key-expansion block can share them.
    localparam logic [0:3][31:0] FK = {
        32'ha3b1bac6, 32'h56aa3350, 32'h677d9197, 32'hb27022dc
    };

    localparam logic [0:31][31:0] CK = {
        32'h00070e15, 32'h1c232a31, 32'h383f464d, 32'h545b6269,
        32'h70777e85, 32'h8c939aa1, 32'ha8afb6bd, 32'hc4cbd2d9,
        32'he0e7eef5, 32'hfc030a11, 32'h181f262d, 32'h343b4249,
        32'h50575e65, 32'h6c737a81, 32'h888f969d, 32'ha4abb2b9,
        32'hc0c7ced5, 32'hdce3eaf1, 32'hf8ff060d, 32'h141b2229,
        32'h30373e45, 32'h4c535a61, 32'h686f767d, 32'h848b9299,
        32'ha0a7aeb5, 32'hbcc3cad1, 32'hd8dfe6ed, 32'hf4fb0209,
        32'h10171e25, 32'h2c333a41, 32'h484f565d, 32'h646b7279
    };

    // Non-linear layer: byte-wise S-box substitution.
    function automatic logic [31:0] sm4_tau(input logic [31:0] a);
        return {SBOX[a[31:24]], SBOX[a[23:16]], SBOX[a[15:8]], SBOX[a[7:0]]};
    endfunction

    // Round transform T = L(tau(a)), L mixes with rotates by 2, 10, 18, 24.
    function automatic logic [31:0] sm4_t(input logic [31:0] a);
        logic [31:0] b;
        b = sm4_tau(a);
        return b ^ {b[29:0], b[31:30]} ^ {b[21:0], b[31:22]}
                 ^ {b[13:0], b[31:14]} ^ {b[7:0],  b[31:8]};
    endfunction

endpackage

// File: rtl/sm4_round_unit.sv
// One SM4 round: {X0,X1,X2,X3} -> {X1,X2,X3, X0 ^ T(X1^X2^X3^rk)}.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the owning engine decides when the result is registered.
// Ports: x_in (128b state, X0 in MSBs), rk (32b round key), x_out (128b next state).
module sm4_round_unit
    import sm4_pkg::*;
(
    input  logic [SM4_BLOCK_W-1:0] x_in,
    input  logic [SM4_WORD_W-1:0]  rk,
    output logic [SM4_BLOCK_W-1:0] x_out
);

    logic [SM4_WORD_W-1:0] x0, x1, x2, x3;

    assign {x0, x1, x2, x3} = x_in;
    assign x_out = {x1, x2, x3, x0 ^ sm4_t(x1 ^ x2 ^ x3 ^ rk)};

endmodule

// File: rtl/sm4_round_engine.sv
// Iterative SM4 block cipher engine, ROUNDS_PER_CYCLE chained rounds per clock (1/2/4/8).
// Latency: accept to out_valid = 32/ROUNDS_PER_CYCLE + 1 cycles; one block in flight.
// Backpressure: result held in DONE until out_ready; in_ready low in BUSY and DONE.
// Ports: clk, reset (async, active high); in_valid/in_ready/in_data/in_decrypt input block
// handshake; rk_all (rk0 in [1023:992], stable while a block is in flight);
// out_valid/out_ready/out_data result handshake (out_data zero when out_valid low).
// Optional: define SM4_ENGINE_ABORT_EN to add the abort input (drops an in-flight block).
module sm4_round_engine
    import sm4_pkg::*;
#(
    parameter int ROUNDS_PER_CYCLE = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [SM4_BLOCK_W-1:0] in_data,
    input  logic                   in_decrypt,
    input  logic [SM4_KEYS_W-1:0]  rk_all,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [SM4_BLOCK_W-1:0] out_data
`ifdef SM4_ENGINE_ABORT_EN
    ,
    input  logic                   abort
`endif
);

    if ((ROUNDS_PER_CYCLE != 1) && (ROUNDS_PER_CYCLE != 2) &&
        (ROUNDS_PER_CYCLE != 4) && (ROUNDS_PER_CYCLE != 8)) begin : g_bad_rpc
        $error("sm4_round_engine: ROUNDS_PER_CYCLE must be 1, 2, 4 or 8");
    end

    localparam logic [4:0] RC_STEP = 5'(ROUNDS_PER_CYCLE);
    localparam logic [4:0] RC_LAST = 5'(SM4_ROUNDS - ROUNDS_PER_CYCLE);

    sm4_state_t             state;
    logic [4:0]             rc;
    logic                   dec;
    logic [SM4_BLOCK_W-1:0] blk;

    logic [SM4_WORD_W-1:0]                     rk_words [SM4_ROUNDS];
    logic [ROUNDS_PER_CYCLE:0][SM4_BLOCK_W-1:0] chain;
    logic [SM4_BLOCK_W-1:0]                    result;

    for (genvar k = 0; k < SM4_ROUNDS; k++) begin : g_rk
        assign rk_words[k] = rk_all[SM4_KEYS_W-1-SM4_WORD_W*k -: SM4_WORD_W];
    end

    assign chain[0] = blk;

    // Round rc+j uses rk[rc+j] to encrypt and rk[31-(rc+j)] to decrypt.
    for (genvar j = 0; j < ROUNDS_PER_CYCLE; j++) begin : g_round
        logic [4:0] rnd;
        logic [4:0] kidx;

        assign rnd  = rc + 5'(j);
        assign kidx = dec ? (5'd31 - rnd) : rnd;

        sm4_round_unit u_round (
            .x_in  (chain[j]),
            .rk    (rk_words[kidx]),
            .x_out (chain[j+1])
        );
    end

    // After the last round the state holds {X32,X33,X34,X35}; output is word-reversed.
    assign result = {chain[ROUNDS_PER_CYCLE][31:0],  chain[ROUNDS_PER_CYCLE][63:32],
                     chain[ROUNDS_PER_CYCLE][95:64], chain[ROUNDS_PER_CYCLE][127:96]};

    // Gated by reset so the engine only advertises readiness once reset is released.
    assign in_ready = (state == ST_IDLE) && !reset;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            rc        <= '0;
            dec       <= 1'b0;
            blk       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        state <= ST_BUSY;
                        blk   <= in_data;
                        rc    <= '0;
                        dec   <= in_decrypt;
                    end
                end
                ST_BUSY: begin
`ifdef SM4_ENGINE_ABORT_EN
                    if (abort) begin
                        // blk keeps stale data; the next accept overwrites it.
                        state <= ST_IDLE;
                        rc    <= '0;
                    end else
`endif
                    begin
                        blk <= chain[ROUNDS_PER_CYCLE];
                        rc  <= rc + RC_STEP;
                        if (rc == RC_LAST) begin
                            state     <= ST_DONE;
                            out_valid <= 1'b1;
                            out_data  <= result;
                        end
                    end
                end
                ST_DONE: begin
`ifdef SM4_ENGINE_ABORT_EN
                    if (abort) begin
                        state     <= ST_IDLE;
                        rc        <= '0;
                        out_valid <= 1'b0;
                        out_data  <= '0;
                    end else
`endif
                    if (out_ready) begin
                        state     <= ST_IDLE;
                        out_valid <= 1'b0;
                        out_data  <= '0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sm4_round_engine.sv
`timescale 1ns/1ps
module tb_sm4_round_engine;

    localparam int N_DUT = 4;   // instance d runs ROUNDS_PER_CYCLE = 1 << d

    logic          clk = 1'b0;
    logic          reset;
    logic          iv   [N_DUT];
    logic          ir   [N_DUT];
    logic          idec [N_DUT];
    logic          ov   [N_DUT];
    logic          ordy [N_DUT];
    logic [127:0]  idat [N_DUT];
    logic [127:0]  odat [N_DUT];
    logic [1023:0] rk_all;
`ifdef SM4_ENGINE_ABORT_EN
    logic          ab   [N_DUT];
`endif

    int checks = 0;
    int errors = 0;
    logic [31:0] rk_tb [32];

    always #5 clk = ~clk;

    for (genvar g = 0; g < N_DUT; g++) begin : g_dut
        sm4_round_engine #(.ROUNDS_PER_CYCLE(1 << g)) u_dut (
            .clk        (clk),
            .reset      (reset),
            .in_valid   (iv[g]),
            .in_ready   (ir[g]),
            .in_data    (idat[g]),
            .in_decrypt (idec[g]),
            .rk_all     (rk_all),
            .out_valid  (ov[g]),
            .out_ready  (ordy[g]),
            .out_data   (odat[g])
`ifdef SM4_ENGINE_ABORT_EN
            ,
            .abort      (ab[g])
`endif
        );
    end

    // Reference S-box, independent copy of the published SM4 table.
    localparam logic [0:255][7:0] TB_SBOX = {
        8'hd6, 8'h90, 8'he9, 8'hfe, 8'hcc, 8'he1, 8'h3d, 8'hb7, 8'h16, 8'hb6, 8'h14, 8'hc2, 8'h28, 8'hfb, 8'h2c, 8'h05,
        8'h2b, 8'h67, 8'h9a, 8'h76, 8'h2a, 8'hbe, 8'h04, 8'hc3, 8'haa, 8'h44, 8'h13, 8'h26, 8'h49, 8'h86, 8'h06, 8'h99,
        8'h9c, 8'h42, 8'h50, 8'hf4, 8'h91, 8'hef, 8'h98, 8'h7a, 8'h33, 8'h54, 8'h0b, 8'h43, 8'hed, 8'hcf, 8'hac, 8'h62,
        8'he4, 8'hb3, 8'h1c, 8'ha9, 8'hc9, 8'h08, 8'he8, 8'h95, 8'h80, 8'hdf, 8'h94, 8'hfa, 8'h75, 8'h8f, 8'h3f, 8'ha6,
        8'h47, 8'h07, 8'ha7, 8'hfc, 8'hf3, 8'h73, 8'h17, 8'hba, 8'h83, 8'h59, 8'h3c, 8'h19, 8'he6, 8'h85, 8'h4f, 8'ha8,
        8'h68, 8'h6b, 8'h81, 8'hb2, 8'h71, 8'h64, 8'hda, 8'h8b, 8'hf8, 8'heb, 8'h0f, 8'h4b, 8'h70, 8'h56, 8'h9d, 8'h35,
        8'h1e, 8'h24, 8'h0e, 8'h5e, 8'h63, 8'h58, 8'hd1, 8'ha2, 8'h25, 8'h22, 8'h7c, 8'h3b, 8'h01, 8'h21, 8'h78, 8'h87,
        8'hd4, 8'h00, 8'h46, 8'h57, 8'h9f, 8'hd3, 8'h27, 8'h52, 8'h4c, 8'h36, 8'h02, 8'he7, 8'ha0, 8'hc4, 8'hc8, 8'h9e,
        8'hea, 8'hbf, 8'h8a, 8'hd2, 8'h40, 8'hc7, 8'h38, 8'hb5, 8'ha3, 8'hf7, 8'hf2, 8'hce, 8'hf9, 8'h61, 8'h15, 8'ha1,
        8'he0, 8'hae, 8'h5d, 8'ha4, 8'h9b, 8'h34, 8'h1a, 8'h55, 8'had, 8'h93, 8'h32, 8'h30, 8'hf5, 8'h8c, 8'hb1, 8'he3,
        8'h1d, 8'hf6, 8'he2, 8'h2e, 8'h82, 8'h66, 8'hca, 8'h60, 8'hc0, 8'h29, 8'h23, 8'hab, 8'h0d, 8'h53, 8'h4e, 8'h6f,
        8'hd5, 8'hdb, 8'h37, 8'h45, 8'hde, 8'hfd, 8'h8e, 8'h2f, 8'h03, 8'hff, 8'h6a, 8'h72, 8'h6d, 8'h6c, 8'h5b, 8'h51,
        8'h8d, 8'h1b, 8'haf, 8'h92, 8'hbb, 8'hdd, 8'hbc, 8'h7f, 8'h11, 8'hd9, 8'h5c, 8'h41, 8'h1f, 8'h10, 8'h5a, 8'hd8,
        8'h0a, 8'hc1, 8'h31, 8'h88, 8'ha5, 8'hcd, 8'h7b, 8'hbd, 8'h2d, 8'h74, 8'hd0, 8'h12, 8'hb8, 8'he5, 8'hb4, 8'hb0,
        8'h89, 8'h69, 8'h97, 8'h4a, 8'h0c, 8'h96, 8'h77, 8'h7e, 8'h65, 8'hb9, 8'hf1, 8'h09, 8'hc5, 8'h6e, 8'hc6, 8'h84,
        8'h18, 8'hf0, 8'h7d, 8'hec, 8'h3a, 8'hdc, 8'h4d, 8'h20, 8'h79, 8'hee, 8'h5f, 8'h3e, 8'hd7, 8'hcb, 8'h39, 8'h48
    };

    // ---------------- reference model ----------------
    function automatic logic [31:0] rol(input logic [31:0] x, input int n);
        return (x << n) | (x >> (32 - n));
    endfunction

    function automatic logic [31:0] tau(input logic [31:0] a);
        return {TB_SBOX[a[31:24]], TB_SBOX[a[23:16]], TB_SBOX[a[15:8]], TB_SBOX[a[7:0]]};
    endfunction

    function automatic logic [31:0] t_enc(input logic [31:0] a);
        logic [31:0] b;
        b = tau(a);
        return b ^ rol(b, 2) ^ rol(b, 10) ^ rol(b, 18) ^ rol(b, 24);
    endfunction

    function automatic logic [31:0] t_key(input logic [31:0] a);
        logic [31:0] b;
        b = tau(a);
        return b ^ rol(b, 13) ^ rol(b, 23);
    endfunction

    // Full SM4 key schedule; CK byte j of word i is (4i+j)*7 mod 256.
    task automatic expand_key(input logic [127:0] key);
        logic [31:0] k [36];
        logic [31:0] ck;
        k[0] = key[127:96] ^ 32'ha3b1bac6;
        k[1] = key[95:64]  ^ 32'h56aa3350;
        k[2] = key[63:32]  ^ 32'h677d9197;
        k[3] = key[31:0]   ^ 32'hb27022dc;
        for (int i = 0; i < 32; i++) begin
            ck = 32'h0;
            for (int j = 0; j < 4; j++) ck = (ck << 8) | 32'(((4 * i + j) * 7) % 256);
            k[i+4] = k[i] ^ t_key(k[i+1] ^ k[i+2] ^ k[i+3] ^ ck);
            rk_tb[i] = k[i+4];
            rk_all[1023 - 32*i -: 32] = k[i+4];
        end
    endtask

    function automatic logic [127:0] ref_crypt(input logic [127:0] blk, input logic dec);
        logic [31:0] x [36];
        logic [31:0] k;
        {x[0], x[1], x[2], x[3]} = blk;
        for (int i = 0; i < 32; i++) begin
            k = dec ? rk_tb[31 - i] : rk_tb[i];
            x[i+4] = x[i] ^ t_enc(x[i+1] ^ x[i+2] ^ x[i+3] ^ k);
        end
        return {x[35], x[34], x[33], x[32]};
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Offers one block, measures accept-to-out_valid latency (accept cycle = 0),
    // captures out_data and completes the output handshake.
    task automatic run_block(input int d, input logic [127:0] blk, input logic dec,
                             output logic [127:0] res, output int lat);
        @(negedge clk);
        idat[d] = blk; idec[d] = dec; iv[d] = 1'b1; ordy[d] = 1'b0;
        @(posedge clk); #1;
        iv[d] = 1'b0; idat[d] = rand128(); idec[d] = ~dec;
        lat = 1;
        while (!ov[d] && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        res = odat[d];
        ordy[d] = 1'b1;
        @(posedge clk); #1;
        ordy[d] = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < N_DUT; d++) begin
            checks++;
            if (ov[d] !== 1'b0) begin errors++; $display("FAIL reset_out_valid[%0d]: got %b want 0", d, ov[d]); end
            checks++;
            if (odat[d] !== 128'h0) begin errors++; $display("FAIL reset_out_data[%0d]: got %h want 0", d, odat[d]); end
            checks++;
            if (ir[d] !== 1'b0) begin errors++; $display("FAIL reset_in_ready_held[%0d]: got %b want 0", d, ir[d]); end
        end
        reset = 1'b0;
        @(posedge clk); #1;
        for (int d = 0; d < N_DUT; d++) begin
            checks++;
            if (ir[d] !== 1'b1) begin errors++; $display("FAIL reset_in_ready_rel[%0d]: got %b want 1", d, ir[d]); end
        end
    endtask

    task automatic test_known_vectors();
        logic [127:0] res;
        int lat;
        expand_key(128'h0123456789abcdeffedcba9876543210);
        checks++;
        if (rk_tb[0] !== 32'hf12186f9) begin errors++; $display("FAIL model_rk0: got %h want f12186f9", rk_tb[0]); end
        checks++;
        if (rk_tb[31] !== 32'h9124a012) begin errors++; $display("FAIL model_rk31: got %h want 9124a012", rk_tb[31]); end
        for (int d = 0; d < N_DUT; d++) begin
            run_block(d, 128'h0123456789abcdeffedcba9876543210, 1'b0, res, lat);
            checks++;
            if (res !== 128'h681edf34d206965e86b3e94f536e4246) begin
                errors++; $display("FAIL kat_encrypt[rpc=%0d]: got %h want 681edf34d206965e86b3e94f536e4246", 1 << d, res);
            end
            checks++;
            if (lat !== 32 / (1 << d) + 1) begin
                errors++; $display("FAIL kat_enc_latency[rpc=%0d]: got %0d want %0d", 1 << d, lat, 32 / (1 << d) + 1);
            end
            run_block(d, 128'h681edf34d206965e86b3e94f536e4246, 1'b1, res, lat);
            checks++;
            if (res !== 128'h0123456789abcdeffedcba9876543210) begin
                errors++; $display("FAIL kat_decrypt[rpc=%0d]: got %h want 0123456789abcdeffedcba9876543210", 1 << d, res);
            end
            checks++;
            if (lat !== 32 / (1 << d) + 1) begin
                errors++; $display("FAIL kat_dec_latency[rpc=%0d]: got %0d want %0d", 1 << d, lat, 32 / (1 << d) + 1);
            end
        end
    endtask

    task automatic test_random();
        logic [127:0] blk, res, exp;
        logic dec;
        int d, lat;
        for (int n = 0; n < 12; n++) begin
            expand_key(rand128());
            blk = rand128();
            dec = 1'($urandom_range(0, 1));
            d   = int'($urandom_range(0, N_DUT - 1));
            exp = ref_crypt(blk, dec);
            run_block(d, blk, dec, res, lat);
            checks++;
            if (res !== exp) begin
                errors++; $display("FAIL random_data[%0d rpc=%0d dec=%b]: got %h want %h", n, 1 << d, dec, res, exp);
            end
            checks++;
            if (lat !== 32 / (1 << d) + 1) begin
                errors++; $display("FAIL random_latency[%0d]: got %0d want %0d", n, lat, 32 / (1 << d) + 1);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [127:0] blk, exp;
        int lat;
        expand_key(rand128());
        blk = rand128();
        exp = ref_crypt(blk, 1'b0);
        @(negedge clk);
        idat[0] = blk; idec[0] = 1'b0; iv[0] = 1'b1; ordy[0] = 1'b0;
        @(posedge clk); #1;
        iv[0] = 1'b0;
        lat = 1;
        while (!ov[0] && lat < 200) begin @(posedge clk); #1; lat++; end
        for (int c = 0; c < 10; c++) begin
            checks++;
            if (odat[0] !== exp) begin errors++; $display("FAIL bp_data[c%0d]: got %h want %h", c, odat[0], exp); end
            checks++;
            if (ov[0] !== 1'b1 || ir[0] !== 1'b0) begin
                errors++; $display("FAIL bp_flags[c%0d]: got valid=%b ready=%b want valid=1 ready=0", c, ov[0], ir[0]);
            end
            iv[0] = 1'(c % 2); idat[0] = rand128();
            @(posedge clk); #1;
        end
        iv[0] = 1'b0; ordy[0] = 1'b1;
        @(posedge clk); #1;
        ordy[0] = 1'b0;
        checks++;
        if (ov[0] !== 1'b0 || odat[0] !== 128'h0) begin
            errors++; $display("FAIL bp_release: got valid=%b data=%h want valid=0 data=0", ov[0], odat[0]);
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (ir[0] !== 1'b1 || ov[0] !== 1'b0) begin
            errors++; $display("FAIL bp_ignored_pulses: got ready=%b valid=%b want ready=1 valid=0", ir[0], ov[0]);
        end
    endtask

    task automatic test_back_to_back();
        logic [127:0] a, b, ra, rb;
        logic [127:0] res [$];
        int acc [$];
        int hs [$];
        int cyc;
        expand_key(rand128());
        a = rand128(); b = rand128();
        ra = ref_crypt(a, 1'b0); rb = ref_crypt(b, 1'b1);
        @(negedge clk);
        idat[1] = a; idec[1] = 1'b0; iv[1] = 1'b1; ordy[1] = 1'b1;
        cyc = 0;
        while (hs.size() < 2 && cyc < 200) begin
            if (iv[1] && ir[1]) acc.push_back(cyc);
            if (ov[1] && ordy[1]) begin hs.push_back(cyc); res.push_back(odat[1]); end
            @(posedge clk); #1;
            if (acc.size() == 1) begin idat[1] = b; idec[1] = 1'b1; end
            if (acc.size() >= 2) iv[1] = 1'b0;
            cyc++;
            @(negedge clk);
        end
        iv[1] = 1'b0; ordy[1] = 1'b0;
        checks++;
        if (acc.size() != 2 || hs.size() != 2) begin
            errors++; $display("FAIL b2b_counts: got accepts=%0d results=%0d want 2 and 2", acc.size(), hs.size());
        end else begin
            checks++;
            if (hs[0] - acc[0] !== 17) begin errors++; $display("FAIL b2b_latency: got %0d want 17", hs[0] - acc[0]); end
            checks++;
            if (acc[1] - hs[0] !== 1) begin errors++; $display("FAIL b2b_reaccept_gap: got %0d want 1", acc[1] - hs[0]); end
            checks++;
            if (res[0] !== ra) begin errors++; $display("FAIL b2b_first: got %h want %h", res[0], ra); end
            checks++;
            if (res[1] !== rb) begin errors++; $display("FAIL b2b_second: got %h want %h", res[1], rb); end
        end
    endtask

    task automatic test_reset_midflight();
        logic [127:0] blk, res, exp;
        int lat;
        bit seen;
        expand_key(rand128());
        // Reset while BUSY at cycle 15.
        @(negedge clk);
        idat[0] = rand128(); idec[0] = 1'b0; iv[0] = 1'b1;
        @(posedge clk); #1;
        iv[0] = 1'b0;
        repeat (14) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        checks++;
        if (ov[0] !== 1'b0 || odat[0] !== 128'h0 || ir[0] !== 1'b0) begin
            errors++; $display("FAIL rst_busy_outputs: got valid=%b ready=%b data=%h want 0/0/0", ov[0], ir[0], odat[0]);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        seen = 1'b0;
        repeat (40) begin @(posedge clk); #1; if (ov[0]) seen = 1'b1; end
        checks++;
        if (seen !== 1'b0 || ir[0] !== 1'b1) begin
            errors++; $display("FAIL rst_busy_discard: got late_valid=%b ready=%b want 0 and 1", seen, ir[0]);
        end
        // Reset while DONE must drop the held result at once.
        @(negedge clk);
        idat[0] = rand128(); iv[0] = 1'b1; ordy[0] = 1'b0;
        @(posedge clk); #1;
        iv[0] = 1'b0;
        lat = 1;
        while (!ov[0] && lat < 200) begin @(posedge clk); #1; lat++; end
        #2 reset = 1'b1;
        #1;
        checks++;
        if (ov[0] !== 1'b0 || odat[0] !== 128'h0) begin
            errors++; $display("FAIL rst_done_outputs: got valid=%b data=%h want 0/0", ov[0], odat[0]);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        blk = rand128();
        exp = ref_crypt(blk, 1'b0);
        run_block(0, blk, 1'b0, res, lat);
        checks++;
        if (res !== exp || lat !== 33) begin
            errors++; $display("FAIL rst_next_block: got %h lat %0d want %h lat 33", res, lat, exp);
        end
    endtask

`ifdef SM4_ENGINE_ABORT_EN
    task automatic test_abort();
        logic [127:0] blk, exp;
        int lat;
        bit seen;
        expand_key(rand128());
        @(negedge clk);
        idat[0] = rand128(); idec[0] = 1'b0; iv[0] = 1'b1; ordy[0] = 1'b0;
        @(posedge clk); #1;
        iv[0] = 1'b0;
        repeat (4) @(posedge clk);
        #1 ab[0] = 1'b1;
        @(posedge clk); #1;
        ab[0] = 1'b0;
        checks++;
        if (ir[0] !== 1'b1 || ov[0] !== 1'b0) begin
            errors++; $display("FAIL abort_busy: got ready=%b valid=%b want 1/0", ir[0], ov[0]);
        end
        seen = 1'b0;
        repeat (40) begin @(posedge clk); #1; if (ov[0]) seen = 1'b1; end
        checks++;
        if (seen !== 1'b0) begin errors++; $display("FAIL abort_no_result: got late_valid=%b want 0", seen); end
        // Abort in IDLE is ignored: the block is still accepted and computed.
        blk = rand128();
        exp = ref_crypt(blk, 1'b1);
        @(negedge clk);
        idat[0] = blk; idec[0] = 1'b1; iv[0] = 1'b1; ab[0] = 1'b1;
        @(posedge clk); #1;
        iv[0] = 1'b0; ab[0] = 1'b0;
        checks++;
        if (ir[0] !== 1'b0) begin errors++; $display("FAIL abort_idle_accept: got ready=%b want 0", ir[0]); end
        lat = 1;
        while (!ov[0] && lat < 200) begin @(posedge clk); #1; lat++; end
        checks++;
        if (odat[0] !== exp) begin errors++; $display("FAIL abort_idle_result: got %h want %h", odat[0], exp); end
        // Abort together with out_ready while DONE.
        ab[0] = 1'b1; ordy[0] = 1'b1;
        @(posedge clk); #1;
        ab[0] = 1'b0; ordy[0] = 1'b0;
        checks++;
        if (ir[0] !== 1'b1 || ov[0] !== 1'b0 || odat[0] !== 128'h0) begin
            errors++; $display("FAIL abort_done: got ready=%b valid=%b data=%h want 1/0/0", ir[0], ov[0], odat[0]);
        end
    endtask
`endif

    initial begin
        reset  = 1'b1;
        rk_all = '0;
        for (int d = 0; d < N_DUT; d++) begin
            iv[d] = 1'b0; idec[d] = 1'b0; ordy[d] = 1'b0; idat[d] = '0;
`ifdef SM4_ENGINE_ABORT_EN
            ab[d] = 1'b0;
`endif
        end
        test_reset();
        test_known_vectors();
        test_random();
        test_backpressure();
        test_back_to_back();
        test_reset_midflight();
`ifdef SM4_ENGINE_ABORT_EN
        test_abort();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
